// File: rtl/tns_encoder_seq_pkg.sv
// Package for the sequential TNS (base-7) TSV crosstalk-avoidance encoder.
// Holds the radix, the group width, the two forbidden group patterns, the
// FSM state type and a helper that derives the input word width from the
// number of 3-TSV groups.
package tns_encoder_seq_pkg;

  localparam int TNS_RADIX = 7;
  localparam int TNS_GRP_W = 3;

  // Forbidden code of a group, selected by that group's previous bit 2
  localparam logic [2:0] TNS_FORBID_P0 = 3'b100;
  localparam logic [2:0] TNS_FORBID_P1 = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    EMIT = 2'd2
  } tns_state_t;

  // floor(log2(7**ng)): widest binary word that always fits in ng base-7 digits
  function automatic int tns_dw(input int ng);
    longint pw;
    int     w;
    pw = 64'sd1;
    for (int i = 0; i < ng; i++) begin
      pw = pw * 64'sd7;
    end
    w = 0;
    while (pw > 64'sd1) begin
      pw = pw >>> 1;
      w  = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/tns_encoder_seq_if.sv
// Handshake/bus interface between the data source and the TNS encoder.
//  in_valid  source -> encoder : datain is valid
//  in_ready  encoder -> source : encoder idle, can accept
//  datain    source -> encoder : DW-bit binary word
//  tsv       encoder -> bundle : registered 3*NG-bit TSV codeword
//  tsv_valid encoder -> bundle : one-cycle pulse after each tsv update
interface tns_encoder_seq_if #(
  parameter int NG = 3
);
  import tns_encoder_seq_pkg::*;

  localparam int DW = tns_dw(NG);

  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   datain;
  logic [3*NG-1:0] tsv;
  logic            tsv_valid;

  modport master (
    output in_valid,
    output datain,
    input  in_ready,
    input  tsv,
    input  tsv_valid
  );

  modport slave (
    input  in_valid,
    input  datain,
    output in_ready,
    output tsv,
    output tsv_valid
  );

endinterface

// File: rtl/tns_encoder_seq_group_map.sv
// Combinational digit-to-code map for one 3-TSV group.
//  digit  in  3 : base-7 digit, 0..6
//  prev   in  1 : bit 2 of this group's previous code
//  code   out 3 : 3-bit code that skips the pattern forbidden after prev
// Codes at or above the forbidden pattern shift up by one, so the seven
// digits land on the seven remaining legal codes.
module tns_encoder_seq_group_map
  import tns_encoder_seq_pkg::*;
(
  input  logic [2:0] digit,
  input  logic       prev,
  output logic [2:0] code
);

  logic [2:0] forbid_s;

  // Pick the forbidden pattern and skip over it
  always_comb begin
    forbid_s = TNS_FORBID_P0;
    code     = digit;
    if (prev) begin
      forbid_s = TNS_FORBID_P1;
    end else begin
      forbid_s = TNS_FORBID_P0;
    end
    if (digit < forbid_s) begin
      code = digit;
    end else begin
      code = digit + 3'd1;
    end
  end

endmodule

// File: rtl/tns_encoder_seq.sv
// Sequential TNS TSV crosstalk-avoidance encoder.
// Accepts a DW-bit word, peels off one base-7 digit per cycle (LSD first),
// then maps all NG digits onto their 3-TSV groups in a single update.
//  clock  in  : single clock, posedge
//  rst_n  in  : synchronous active-low reset
//  bus    slave modport of tns_encoder_seq_if (in_valid/in_ready/datain,
//         tsv/tsv_valid)
// One word every NG+2 cycles; tsv only changes on the EMIT edge.
module tns_encoder_seq
  import tns_encoder_seq_pkg::*;
#(
  parameter int NG = 3
) (
  input  logic                  clock,
  input  logic                  rst_n,
  tns_encoder_seq_if.slave      bus
);

  localparam int DW = tns_dw(NG);
  localparam int CW = $clog2(NG + 1);
  localparam int TW = NG * TNS_GRP_W;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CONV = CONV;
  localparam logic [1:0] ST_EMIT = EMIT;

  logic [1:0]          state_q, state_d;
  logic [DW-1:0]       rem_q, rem_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NG-1:0][2:0]  digit_q, digit_d;
  logic [TW-1:0]       tsv_q, tsv_d;
  logic                tsv_valid_q, tsv_valid_d;

  logic [DW-1:0]       rem_div_s;
  logic [2:0]          rem_mod_s;
  logic [NG-1:0][2:0]  code_s;

  assign rem_div_s = rem_q / DW'(TNS_RADIX);
  assign rem_mod_s = 3'(rem_q % DW'(TNS_RADIX));

  // Each group's map sees its own previous bit 2 straight from the tsv register
  for (genvar j = 0; j < NG; j++) begin : g_map
    tns_encoder_seq_group_map u_map (
      .digit (digit_q[j]),
      .prev  (tsv_q[TNS_GRP_W*j+2]),
      .code  (code_s[j])
    );
  end

  // Next-state logic: accept, convert one digit per cycle, then emit
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    digit_d     = digit_q;
    tsv_d       = tsv_q;
    tsv_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          rem_d   = bus.datain;
          cnt_d   = {CW{1'b0}};
          state_d = ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        digit_d[cnt_q] = rem_mod_s;
        rem_d          = rem_div_s;
        cnt_d          = cnt_q + CW'(1);
        if (cnt_q == CW'(NG - 1)) begin
          state_d = ST_EMIT;
        end else begin
          state_d = ST_CONV;
        end
      end
      ST_EMIT: begin
        tsv_d       = code_s;
        tsv_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= {DW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      digit_q     <= '0;
      tsv_q       <= {TW{1'b0}};
      tsv_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      tsv_q       <= tsv_d;
      tsv_valid_q <= tsv_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.tsv       = tsv_q;
  assign bus.tsv_valid = tsv_valid_q;

endmodule

// File: tb/tb_tns_encoder_seq.sv
// Self-checking bench for tns_encoder_seq (NG=3, DW=8): directed words,
// reset mid-conversion, ignored in_valid/datain during conversion, and a
// long back-to-back random run checked against a base-7 reference model.
module tb_tns_encoder_seq;

  localparam int NG     = 3;
  localparam int DW     = 8;
  localparam int TW     = 3 * NG;
  localparam int N_RAND = 10000;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  always #5 clock = ~clock;

  tns_encoder_seq_if #(.NG(NG)) bus ();

  tns_encoder_seq #(.NG(NG)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int valid_cnt = 0;
  int acc_cnt   = 0;
  int last_acc  = -1;
  bit mon_en    = 1'b0;
  bit b2b       = 1'b0;

  logic [DW-1:0] exp_q[$];
  int            acc_q[$];
  logic [TW-1:0] model_tsv = '0;

  logic [DW-1:0] m_d;
  int            m_a;
  logic [TW-1:0] m_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference encoder: base-7 digits, each skipping the pattern forbidden after its prev bit
  function automatic logic [TW-1:0] enc(input int d, input logic [TW-1:0] prev);
    logic [TW-1:0] r;
    int v, dig, f;
    r = '0;
    v = d;
    for (int j = 0; j < NG; j++) begin
      dig = v % 7;
      v   = v / 7;
      f   = prev[3*j+2] ? 3 : 4;
      r[3*j +: 3] = 3'((dig < f) ? dig : dig + 1);
    end
    return r;
  endfunction

  // Reference decoder using the model's own previous bits
  function automatic int dec(input logic [TW-1:0] t, input logic [TW-1:0] prev);
    int val, w, c, f;
    val = 0;
    w   = 1;
    for (int j = 0; j < NG; j++) begin
      c   = int'(t[3*j +: 3]);
      f   = prev[3*j+2] ? 3 : 4;
      val = val + ((c < f) ? c : c - 1) * w;
      w   = w * 7;
    end
    return val;
  endfunction

  function automatic int n_forbid(input logic [TW-1:0] t, input logic [TW-1:0] prev);
    int n;
    n = 0;
    for (int j = 0; j < NG; j++) begin
      if (int'(t[3*j +: 3]) == (prev[3*j+2] ? 3 : 4)) n++;
    end
    return n;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Accept detector: a handshake seen here is taken on the next posedge
  always @(negedge clock) begin
    if (mon_en && rst_n && bus.in_valid && bus.in_ready) begin
      exp_q.push_back(bus.datain);
      acc_q.push_back(cyc + 1);
      if (b2b && last_acc >= 0) chk("accept_interval", cyc + 1 - last_acc, NG + 2);
      last_acc = cyc + 1;
      acc_cnt++;
    end
  end

  // Output monitor: every update must match the model, otherwise tsv must hold
  always @(negedge clock) begin
    if (mon_en && rst_n) begin
      if (bus.tsv_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          chk("spurious_tsv_valid", 32'd1, 32'd0);
        end else begin
          m_d = exp_q.pop_front();
          m_a = acc_q.pop_front();
          m_e = enc(int'(m_d), model_tsv);
          chk("tsv_word", bus.tsv, m_e);
          chk("decode", dec(bus.tsv, model_tsv), m_d);
          chk("forbidden", n_forbid(bus.tsv, model_tsv), 0);
          chk("latency", cyc - m_a, NG + 1);
          model_tsv = m_e;
        end
      end else begin
        chk("tsv_hold", bus.tsv, model_tsv);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_model();
    exp_q.delete();
    acc_q.delete();
    model_tsv = '0;
    last_acc  = -1;
  endtask

  task automatic do_reset();
    mon_en       = 1'b0;
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    tick();
    tick();
    clear_model();
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Present a word and hold in_valid until it is accepted; returns just after the accept edge
  task automatic send(input logic [DW-1:0] d);
    int g;
    g = 0;
    bus.datain   = d;
    bus.in_valid = 1'b1;
    @(negedge clock);
    while (!bus.in_ready && g < 50) begin
      @(negedge clock);
      g++;
    end
    if (g >= 50) chk("accept_timeout", 32'd1, 32'd0);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for the tsv_valid pulse; returns at that negedge with tsv captured
  task automatic wait_valid(output logic [TW-1:0] t);
    int g;
    g = 0;
    @(negedge clock);
    while (!bus.tsv_valid && g < 20) begin
      @(negedge clock);
      g++;
    end
    chk("tsv_valid_seen", bus.tsv_valid, 1);
    t = bus.tsv;
  endtask

  logic [TW-1:0] t;
  int vc0, n0, g;

  initial begin
    bus.in_valid = 1'b0;
    bus.datain   = '0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_tsv", bus.tsv, 0);
    chk("rst_tsv_valid", bus.tsv_valid, 0);
    tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Zero word, single pulse
    send(8'd0);
    wait_valid(t);
    chk("zero_word", t, 9'b000_000_000);
    @(negedge clock);
    chk("single_pulse", bus.tsv_valid, 0);
    chk("ready_after_emit", bus.in_ready, 1);
    tick();

    // 255 from reset, then 200 using the new previous bits
    do_reset();
    send(8'd255);
    wait_valid(t);
    chk("w255", t, 9'b110_001_011);
    chk("w255_prev", {t[8], t[5], t[2]}, 3'b100);
    tick();
    send(8'd200);
    wait_valid(t);
    chk("w200", t, 9'b101_000_101);
    tick();

    // in_valid pulse and datain changes during conversion are ignored
    vc0 = valid_cnt;
    send(8'd77);
    bus.datain   = 8'd200;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.datain   = 8'd13;
    tick();
    bus.datain   = 8'd250;
    wait_valid(t);
    repeat (6) @(negedge clock);
    chk("ignore_one_pulse", valid_cnt - vc0, 1);
    tick();

    // Reset during the second conversion cycle drops the word
    send(8'd99);
    tick();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_model();
    @(negedge clock);
    chk("rst_mid_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      chk("rst_mid_tsv", bus.tsv, 0);
      chk("rst_mid_no_valid", bus.tsv_valid, 0);
      @(negedge clock);
    end
    mon_en = 1'b1;
    tick();
    send(8'd123);
    wait_valid(t);
    chk("post_reset_word", t, 9'b010_011_101);
    tick();

    // Back-to-back random words with in_valid held high
    last_acc     = -1;
    b2b          = 1'b1;
    n0           = acc_cnt;
    g            = 0;
    bus.in_valid = 1'b1;
    while ((acc_cnt - n0) < N_RAND && g < 60000) begin
      bus.datain = DW'($urandom);
      tick();
      g++;
    end
    bus.in_valid = 1'b0;
    chk("rand_accepts", acc_cnt - n0, N_RAND);
    wait_valid(t);
    b2b = 1'b0;
    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
